// File: rtl/full_adder_pkg.sv
// Shared constants and 1-bit golden functions for the full_adder block.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder_fa_bit.sv
// Combinational 1-bit full adder cell, the ripple stage of full_adder.
module fa_bit
    import full_adder_pkg::*;
(
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = fa_sum(a, b, ci);
    assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple full adder with one-cycle latency.
// Optional feature: define FULL_ADDER_OVF_EN to add the registered overflow output ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the carry out of the MSB
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    assign carry_s[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        fa_bit u_fa_bit (
            .s  (sum_s[i]),
            .co (carry_s[i+1]),
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry_s[i])
        );
    end

    // Output result registers: reset clears, valid captures, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= {WIDTH{1'b0}};
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            s         <= sum_s;
            c_out     <= carry_s[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow register, updated and held in lockstep with c_out
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= carry_s[WIDTH] ^ carry_s[WIDTH-1];
        end else begin
            ovf <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;

    logic       clk;
    logic       rst;

    logic       a1, b1, c_in1, in_valid1;
    logic       s1, c_out1, out_valid1;
    logic [3:0] a4, b4;
    logic       c_in4, in_valid4;
    logic [3:0] s4;
    logic       c_out4, out_valid4;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf1, ovf4;
`endif

    int n_vec;
    int n_err;

    // hand-derived per-combination results, bit index = {a,b,c_in}
    logic [7:0] exp_s1_tab;
    logic [7:0] exp_c1_tab;
    logic [7:0] exp_o1_tab;
    logic [2:0] idx;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .s         (s1),
        .c_out     (c_out1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .in_valid  (in_valid1),
        .out_valid (out_valid1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .s         (s4),
        .c_out     (c_out4),
        .a         (a4),
        .b         (b4),
        .c_in      (c_in4),
        .in_valid  (in_valid4),
        .out_valid (out_valid4)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] es, input logic ec,
                          input logic ev, input logic eo);
        check_eq({tag, ".s"}, {4'h0, s4}, {4'h0, es});
        check_eq({tag, ".c_out"}, {7'h00, c_out4}, {7'h00, ec});
        check_eq({tag, ".out_valid"}, {7'h00, out_valid4}, {7'h00, ev});
`ifdef FULL_ADDER_OVF_EN
        check_eq({tag, ".ovf"}, {7'h00, ovf4}, {7'h00, eo});
`else
        if (eo === 1'bx) $display("note: unexpected unknown overflow expectation in %s", tag);
`endif
    endtask

    task automatic drive4(input logic [3:0] va, input logic [3:0] vb, input logic vc, input logic vv);
        a4        = va;
        b4        = vb;
        c_in4     = vc;
        in_valid4 = vv;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_s1_tab = 8'b1001_0110;
        exp_c1_tab = 8'b1110_1000;
        exp_o1_tab = 8'b0100_0010;

        // reset for two cycles with random operands and valid
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            a1        = 1'($urandom_range(1, 0));
            b1        = 1'($urandom_range(1, 0));
            c_in1     = 1'($urandom_range(1, 0));
            in_valid1 = 1'($urandom_range(1, 0));
            drive4(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                   1'($urandom_range(1, 0)), 1'b1);
            step();
            check_eq("rst.w1.s", {7'h00, s1}, 8'h00);
            check_eq("rst.w1.c_out", {7'h00, c_out1}, 8'h00);
            check_eq("rst.w1.out_valid", {7'h00, out_valid1}, 8'h00);
            check4("rst.w4", 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef FULL_ADDER_OVF_EN
            check_eq("rst.w1.ovf", {7'h00, ovf1}, 8'h00);
`endif
        end

        // WIDTH=1 exhaustive, back-to-back
        rst = 1'b0;
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idx       = 3'(i);
            a1        = idx[2];
            b1        = idx[1];
            c_in1     = idx[0];
            in_valid1 = 1'b1;
            step();
            check_eq($sformatf("w1.%0d.s", i), {7'h00, s1}, {7'h00, exp_s1_tab[idx]});
            check_eq($sformatf("w1.%0d.c_out", i), {7'h00, c_out1}, {7'h00, exp_c1_tab[idx]});
            check_eq($sformatf("w1.%0d.out_valid", i), {7'h00, out_valid1}, 8'h01);
`ifdef FULL_ADDER_OVF_EN
            check_eq($sformatf("w1.%0d.ovf", i), {7'h00, ovf1}, {7'h00, exp_o1_tab[idx]});
`endif
        end
        check4("w4.idle", 4'h0, 1'b0, 1'b0, 1'b0);
        in_valid1 = 1'b0;

        // WIDTH=4 directed, back-to-back
        drive4(4'h8, 4'h8, 1'b1, 1'b1);
        step();
        check4("w4.8+8+1", 4'h1, 1'b1, 1'b1, 1'b1);
        drive4(4'hF, 4'h0, 1'b1, 1'b1);
        step();
        check4("w4.F+0+1", 4'h0, 1'b1, 1'b1, 1'b0);
        drive4(4'h7, 4'h1, 1'b0, 1'b1);
        step();
        check4("w4.7+1+0", 4'h8, 1'b0, 1'b1, 1'b1);
        drive4(4'hF, 4'hF, 1'b1, 1'b1);
        step();
        check4("w4.F+F+1", 4'hF, 1'b1, 1'b1, 1'b0);
        drive4(4'h5, 4'h2, 1'b0, 1'b1);
        step();
        check4("w4.5+2+0", 4'h7, 1'b0, 1'b1, 1'b0);

        // hold: one valid pulse then idle with changing operands
        drive4(4'h3, 4'h4, 1'b0, 1'b1);
        step();
        check4("hold.cap", 4'h7, 1'b0, 1'b1, 1'b0);
        for (int h = 0; h < 3; h++) begin
            drive4(4'($urandom_range(15, 0)), 4'hF, 1'b1, 1'b0);
            step();
            check4($sformatf("hold.%0d", h), 4'h7, 1'b0, 1'b0, 1'b0);
        end

        // reset overrides a valid operand on the same cycle
        rst = 1'b1;
        drive4(4'hF, 4'hF, 1'b1, 1'b1);
        step();
        check4("rst.mid", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive4(4'h9, 4'h9, 1'b0, 1'b0);
        step();
        check4("rst.after", 4'h0, 1'b0, 1'b0, 1'b0);
        drive4(4'h9, 4'h9, 1'b0, 1'b1);
        step();
        check4("recover.9+9", 4'h2, 1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
